// File: rtl/store_narrow_buffer_if.sv
// Store-path bus bundle: MEM-stage store request side and data-memory write side.
// slave = buffer view (takes stores, drives memory); master = pipeline/memory view.
interface store_narrow_buffer_if #(
    parameter int AW = 32
);
    logic          st_valid;
    logic          st_ready;
    logic [AW-1:0] st_addr;
    logic [1:0]    st_size;
    logic [31:0]   st_data;
    logic          mem_req;
    logic          mem_ack;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wstrb;

    modport slave (
        input  st_valid, st_addr, st_size, st_data, mem_ack,
        output st_ready, mem_req, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output st_valid, st_addr, st_size, st_data, mem_ack,
        input  st_ready, mem_req, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/store_narrow_buffer.sv
// MEM-stage store narrowing + write FIFO draining to data memory over req/ack.
// Ports: clk, resetn (async low), bus (slave: st_* in, mem_* out), buf_empty.
// Optional STORE_MISALIGN_EXC_EN adds misalign_exc / bad_vaddr.
module store_narrow_buffer #(
    parameter int DEPTH = 2,
    parameter int AW    = 32
) (
    input  logic                clk,
    input  logic                resetn,
    store_narrow_buffer_if.slave bus,
`ifdef STORE_MISALIGN_EXC_EN
    output logic                misalign_exc,
    output logic [AW-1:0]       bad_vaddr,
`endif
    output logic                buf_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic [AW-1:0] addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [3:0]    strb_q [DEPTH];

    logic [31:0] n_data;
    logic [3:0]  n_strb;
    logic        size_ok;
    logic        misaligned;
    logic        accept;
    logic        enq;
    logic        deq;

    always_comb begin
        n_data     = bus.st_data;
        n_strb     = 4'b0000;
        size_ok    = 1'b1;
        misaligned = 1'b0;
        unique case (1'b1)
            bus.st_size == 2'b00: begin
                n_data = {4{bus.st_data[7:0]}};
                n_strb = 4'b0001 << bus.st_addr[1:0];
            end
            bus.st_size == 2'b01: begin
                n_data     = {2{bus.st_data[15:0]}};
                n_strb     = bus.st_addr[1] ? 4'b1100 : 4'b0011;
                misaligned = bus.st_addr[0];
            end
            bus.st_size == 2'b10: begin
                n_strb     = 4'b1111;
                misaligned = bus.st_addr[1:0] != 2'b00;
            end
            default: size_ok = 1'b0;
        endcase
    end

    assign bus.st_ready = count != CW'(DEPTH);
    assign bus.mem_req  = count != '0;
    assign buf_empty    = count == '0;
    assign accept       = bus.st_valid & bus.st_ready;
    assign deq          = bus.mem_req & bus.mem_ack;

`ifdef STORE_MISALIGN_EXC_EN
    // Misaligned stores are consumed but never reach memory.
    assign enq = accept & size_ok & ~misaligned;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            misalign_exc <= 1'b0;
            bad_vaddr    <= '0;
        end else begin
            misalign_exc <= accept & size_ok & misaligned;
            if (accept & size_ok & misaligned)
                bad_vaddr <= bus.st_addr;
        end
    end
`else
    // Without the exception the lane logic already truncates the offset.
    logic unused_mis;
    assign unused_mis = misaligned;
    assign enq        = accept & size_ok;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                strb_q[i] <= '0;
            end
        end else begin
            if (enq) begin
                addr_q[wr_ptr] <= {bus.st_addr[AW-1:2], 2'b00};
                data_q[wr_ptr] <= n_data;
                strb_q[wr_ptr] <= n_strb;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (deq)
                rd_ptr <= rd_ptr + 1'b1;
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign bus.mem_addr  = addr_q[rd_ptr];
    assign bus.mem_wdata = data_q[rd_ptr];
    assign bus.mem_wstrb = strb_q[rd_ptr];
endmodule
